ram_word_gen: RTL and testbench
===============================

Name: ram_word_gen

Overview:
- Small synchronous single-port RAM paired with an on-chip word generator that supplies all write data.
- The generator advances one step on each rising edge of a "next" strobe. A chip-select/write-enable strobe stores the current generator word at the addressed location. A chip-select/output-enable strobe reads a location out.
- Used as the basic storage block under test in the RAM BIST environment.

Parameters:
- ADDR_W, 2, address width in bits; DEPTH = 2**ADDR_W words (4 by default).
- WORD_W, 3, data word width in bits.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- address  in  ADDR_W  word address for read and write.
- cs  in  1  chip select; no read or write occurs while low.
- we  in  1  write enable; qualified by cs.
- oe  in  1  output enable; qualified by cs.
- gen_next  in  1  generator advance request, level input, edge-detected internally.
- data  out  WORD_W  current generator word; this is the RAM write data.
- dout  out  WORD_W  last word read from the RAM; holds between reads.
- dout_valid  out  1  one-cycle pulse marking a fresh dout value.

Behaviour:
- Reset (rst=1 at a clk edge):
  - data=0, dout=0, dout_valid=0.
  - Internal gen_next history flop = 0.
  - All DEPTH memory words cleared to 0.
  - Reset overrides every other input in that cycle; a reset mid-sequence discards any pending strobe.
- Generator:
  - gen_next is sampled each clk into gen_next_q.
  - A rising edge is gen_next=1 and gen_next_q=0.
  - On a rising edge, data <= data + 1, modulo 2**WORD_W, so 7 wraps to 0.
  - A level held high advances only once.
- Write:
  - When cs=1 and we=1, mem[address] <= data at the clk edge.
  - The stored value is data as it was before that edge. A generator step in the same cycle does not affect the word written.
  - Write latency: 1 cycle; the new value is readable from the next cycle on.
- Read:
  - When cs=1, oe=1 and we=0:
    - dout <= mem[address] at the clk edge.
    - dout_valid=1 in the following cycle only.
  - Read latency: 1 cycle.
  - Back-to-back reads give one dout_valid pulse per read cycle.
- Simultaneous strobes:
  - cs=1, we=1, oe=1: the write executes and the read is suppressed; dout holds and dout_valid=0.
  - cs=0: we and oe are ignored.
- Holding dout:
  - dout keeps its last read value until the next read or reset.
  - No high-impedance state; dout_valid replaces tri-state detection.
- Addressing: the full address range is valid. No out-of-range condition exists; address wrap is the caller's concern.
- All outputs are registered.

Decomposition:
- Shared package holds:
  - default ADDR_W=2 and WORD_W=3
  - derived DEPTH
  - word and address typedefs
- One sub-module, ram_word_gen_src, contains the gen_next edge detector and the modulo counter driving data.
- The memory array and read/write control stay in the top.

Test Plan:
- Reset, then read addresses 0..3 with cs=oe=1 one per cycle -> dout=0 each time, with four dout_valid pulses, each one cycle after its strobe.
- Fill and read back:
  - Fill loop over 4 iterations: gen_next=0 -> pulse cs=we=1 at address i -> gen_next=1, address++.
  - Then read 0..3 -> dout sequence 0,1,2,3 and data=4 at the end.
- Hold gen_next high for 5 cycles -> data advances exactly once. Pulse it 8 times from reset -> data wraps to 0.
- Same-cycle gen_next rise and write at address 2 with data=5 -> mem[2]=5 and data=6 afterwards.
- Same-cycle write and read conflict, then cs-low check:
  - cs=we=oe=1 at address 1 with data=3 -> no dout_valid and dout unchanged; a subsequent read of address 1 gives 3.
  - cs=0 with we=1 -> memory unchanged.
- Mid-sequence reset:
  - Write 1,2 to addresses 0,1, assert rst for one cycle, then read 0..1 -> dout=0, 0 and data=0.

Source files
------------

// File: rtl/ram_word_gen_pkg.sv
// ----------------------------------------------------------------------------
// ram_word_gen_pkg
//   Shared definitions for the RAM / word-generator block.
//   Holds the default geometry (address and word widths), the derived
//   memory depth, and convenience typedefs for words and addresses at the
//   default geometry.
// ----------------------------------------------------------------------------
package ram_word_gen_pkg;

    localparam int ADDR_W_DEF = 2;
    localparam int WORD_W_DEF = 3;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    typedef logic [WORD_W_DEF-1:0] word_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage : ram_word_gen_pkg

// File: rtl/ram_word_gen_src.sv
// ----------------------------------------------------------------------------
// ram_word_gen_src
//   Word generator feeding the RAM write port. A rising edge on the level
//   input gen_next advances the output word by one, wrapping modulo
//   2**WORD_W. A level held high advances only once.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-high
//   gen_next  in   advance request (level, edge-detected here)
//   data      out  current generator word (registered)
// ----------------------------------------------------------------------------
module ram_word_gen_src
    import ram_word_gen_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gen_next,
    output logic [WORD_W-1:0] data
);

    logic gen_next_q;
    logic gen_rise;

    assign gen_rise = gen_next & ~gen_next_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gen_next_q <= 1'b0;
            data       <= '0;
        end else begin
            gen_next_q <= gen_next;
            // Natural overflow of the WORD_W-bit add gives the modulo wrap.
            if (gen_rise) begin
                data <= data + WORD_W'(1);
            end
        end
    end

endmodule : ram_word_gen_src

// File: rtl/ram_word_gen.sv
// ----------------------------------------------------------------------------
// ram_word_gen
//   Small synchronous single-port RAM whose write data always comes from an
//   on-chip word generator. Used as the storage block exercised by the RAM
//   BIST environment.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous reset, active-high; clears memory too
//   address     in   word address for read and write
//   cs          in   chip select; qualifies we and oe
//   we          in   write enable: mem[address] <= data
//   oe          in   output enable: dout <= mem[address] (only when we=0)
//   gen_next    in   generator advance request (edge-detected)
//   data        out  current generator word = RAM write data
//   dout        out  last word read; holds between reads
//   dout_valid  out  one-cycle pulse marking a fresh dout
// ----------------------------------------------------------------------------
module ram_word_gen
    import ram_word_gen_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              cs,
    input  logic              we,
    input  logic              oe,
    input  logic              gen_next,
    output logic [WORD_W-1:0] data,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];
    logic              wr_en;
    logic              rd_en;

    ram_word_gen_src #(
        .WORD_W (WORD_W)
    ) u_src (
        .clk      (clk),
        .rst      (rst),
        .gen_next (gen_next),
        .data     (data)
    );

    // Write wins over read when both are strobed in the same cycle.
    assign wr_en = cs & we;
    assign rd_en = cs & oe & ~we;

    // data is a register, so the word written here is the pre-edge value even
    // when the generator steps on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[address] <= data;
            end
            if (rd_en) begin
                dout <= mem[address];
            end
            dout_valid <= rd_en;
        end
    end

endmodule : ram_word_gen

// File: tb/tb_ram_word_gen.sv
module tb_ram_word_gen;
    import ram_word_gen_pkg::*;

    logic  clk = 1'b0;
    logic  rst, cs, we, oe, gen_next;
    addr_t address;
    word_t data, dout;
    logic  dout_valid;

    int checks = 0;
    int errors = 0;

    // Behavioural reference state
    int m_mem [DEPTH_DEF];
    int m_gen;
    bit m_prev;
    int m_dout;
    bit m_valid;

    ram_word_gen dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .cs         (cs),
        .we         (we),
        .oe         (oe),
        .gen_next   (gen_next),
        .data       (data),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string nm;
        bit    r, c, w, o, g;
        int    a;
        int    ed, edo, ev;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string nm, bit r, bit c, bit w, bit o, bit g, int a,
                                int ed, int edo, int ev);
        vec_t v;
        v.nm = nm; v.r = r; v.c = c; v.w = w; v.o = o; v.g = g; v.a = a;
        v.ed = ed; v.edo = edo; v.ev = ev;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int ed, input int edo, input int ev);
        chk({nm, ".data"}, int'(data), ed);
        chk({nm, ".dout"}, int'(dout), edo);
        chk({nm, ".valid"}, int'(dout_valid), ev);
    endtask

    // Drive one cycle, clock it, and advance the reference model.
    task automatic step(input bit r, input bit c, input bit w, input bit o,
                        input bit g, input int a);
        rst = r; cs = c; we = w; oe = o; gen_next = g; address = addr_t'(a);
        @(posedge clk);
        #1;
        if (r) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_gen = 0; m_prev = 0; m_dout = 0; m_valid = 0;
        end else begin
            m_valid = c && o && !w;
            if (m_valid) m_dout = m_mem[a];
            if (c && w) m_mem[a] = m_gen;
            if (g && !m_prev) m_gen = (m_gen + 1) % 8;
            m_prev = g;
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse_gen();
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; cs = 0; we = 0; oe = 0; gen_next = 0; address = '0;

        // ---- table: reset, read-after-reset, fill, read back ----
        add("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add($sformatf("rd0_%0d", i), 0, 1, 0, 1, 0, i, 0, 0, 1);
        add("idle0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            add($sformatf("fill_wr%0d", i), 0, 1, 1, 0, 0, i, i, 0, 0);
            add($sformatf("fill_gn%0d", i), 0, 0, 0, 0, 1, i + 1, i + 1, 0, 0);
        end
        for (int i = 0; i < 4; i++) add($sformatf("rdback%0d", i), 0, 1, 0, 1, 0, i, 4, i, 1);
        add("idle1", 0, 0, 0, 0, 0, 0, 4, 3, 0);

        foreach (vecs[k]) begin
            step(vecs[k].r, vecs[k].c, vecs[k].w, vecs[k].o, vecs[k].g, vecs[k].a);
            chk_out(vecs[k].nm, vecs[k].ed, vecs[k].edo, vecs[k].ev);
        end

        // ---- gen_next held high advances once ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 0);
            chk($sformatf("hold%0d", i), int'(data), 1);
        end
        step(0, 0, 0, 0, 0, 0);
        chk("hold_release", int'(data), 1);

        // ---- eight pulses wrap to 0 ----
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            pulse_gen();
            chk($sformatf("wrap%0d", k), int'(data), k % 8);
        end

        // ---- same-cycle generator step and write ----
        do_reset();
        for (int k = 0; k < 5; k++) pulse_gen();
        chk("pre_same", int'(data), 5);
        step(0, 1, 1, 0, 1, 2);
        chk("same_data", int'(data), 6);
        step(0, 1, 0, 1, 0, 2);
        chk_out("same_rd", 6, 5, 1);

        // ---- write/read conflict, then cs low ----
        do_reset();
        pulse_gen();
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        chk_out("cf_prime", 1, 1, 1);
        pulse_gen();
        pulse_gen();
        step(0, 1, 1, 1, 0, 1);
        chk_out("cf_conflict", 3, 1, 0);
        step(0, 1, 0, 1, 0, 1);
        chk_out("cf_rd1", 3, 3, 1);
        pulse_gen();
        step(0, 0, 1, 1, 0, 1);
        chk_out("cs_low", 4, 3, 0);
        step(0, 1, 0, 1, 0, 1);
        chk_out("cs_low_rd", 4, 3, 1);

        // ---- mid-sequence reset ----
        do_reset();
        pulse_gen();
        step(0, 1, 1, 0, 0, 0);
        pulse_gen();
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 0, 1, 0, 1);
        chk_out("mr_pre", 2, 2, 1);
        step(1, 1, 1, 0, 1, 1);
        chk_out("mr_rst", 0, 0, 0);
        step(0, 1, 0, 1, 0, 0);
        chk_out("mr_rd0", 0, 0, 1);
        step(0, 1, 0, 1, 0, 1);
        chk_out("mr_rd1", 0, 0, 1);

        // ---- randomized against the reference model ----
        do_reset();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(31) == 0, $urandom_range(3) != 0, 1'($urandom),
                 1'($urandom), 1'($urandom), int'($urandom_range(DEPTH_DEF - 1)));
            chk($sformatf("rnd%0d.data", n), int'(data), m_gen);
            chk($sformatf("rnd%0d.dout", n), int'(dout), m_dout);
            chk($sformatf("rnd%0d.valid", n), int'(dout_valid), int'(m_valid));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram_word_gen
